// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode-class helpers for alu_seq.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0011;
    localparam logic [3:0] OP_MULHU = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_REMU  = 4'b1100;
    localparam logic [3:0] OP_XOR   = 4'b1101;
    localparam logic [3:0] OP_DIV   = 4'b1110;
    localparam logic [3:0] OP_REM   = 4'b1111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    function automatic logic is_muldiv(input logic [3:0] op);
        return is_mul(op) || (op == OP_DIVU) || (op == OP_REMU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Signed divide works on magnitudes and fixes signs on the final value.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);

    logic              active;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   m;
    logic [3:0]        op_q;
    logic              neg_q, neg_r, dz;
    logic              signed_op;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   lo, hi;

    // Operand magnitudes for signed divide/remainder; unsigned ops pass through.
    always_comb begin
        signed_op = (op == OP_DIV) || (op == OP_REM);
        a_mag     = (signed_op && a[XLEN-1]) ? -a : a;
        b_mag     = (signed_op && b[XLEN-1]) ? -b : b;
    end

    // One iteration: acc is {hi, lo} = {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_trial = div_shift - {1'b0, m};
        if (is_mul(op_q)) begin
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        end else if (div_shift >= {1'b0, m}) begin
            acc_nxt = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    // Final value is taken from the post-iteration state so the top can register it on the last step.
    always_comb begin
        lo   = acc_nxt[XLEN-1:0];
        hi   = acc_nxt[2*XLEN-1:XLEN];
        done = active && (count == CW'(XLEN - 1));
        case (op_q)
            OP_MUL:   result = lo;
            OP_MULHU: result = hi;
            OP_DIVU:  result = lo;
            OP_REMU:  result = hi;
            OP_DIV:   result = dz ? '1 : (neg_q ? -lo : lo);
            OP_REM:   result = neg_r ? -hi : hi;
            default:  result = '0;
        endcase
    end

    // Operand capture on start, then XLEN iterations while active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= 1'b0;
            count  <= '0;
            acc    <= '0;
            m      <= '0;
            op_q   <= OP_MUL;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (kill) begin
            active <= 1'b0;
            count  <= '0;
        end else if (start) begin
            active <= 1'b1;
            count  <= '0;
            op_q   <= op;
            if (is_mul(op)) begin
                acc <= {{XLEN{1'b0}}, b};
                m   <= a;
            end else begin
                acc <= {{XLEN{1'b0}}, a_mag};
                m   <= b_mag;
            end
            neg_q <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r <= signed_op && a[XLEN-1];
            dz    <= (b == '0);
        end else if (active) begin
            acc   <= acc_nxt;
            count <= count + CW'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift ops plus optional
// iterative mul/div, with a registered result held until consumed.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [3:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [1:0]      state;
    logic            accept;
    logic            start_md;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic [XLEN-1:0] simple_res;
    logic [SHW-1:0]  shamt;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready && !kill;
    assign start_md  = accept && MULDIV_EN && is_muldiv(alu_op);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_BUSY);

    // Single-cycle datapath; mul/div codes yield 0 here (used directly when the iterative unit is absent).
    always_comb begin
        simple_res = '0;
        shamt      = op2[SHW-1:0];
        case (alu_op)
            OP_AND:   simple_res = op1 & op2;
            OP_OR:    simple_res = op1 | op2;
            OP_ADD:   simple_res = op1 + op2;
            OP_SUB:   simple_res = op1 - op2;
            OP_XOR:   simple_res = op1 ^ op2;
            OP_SLTU:  simple_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            OP_SLT:   simple_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SRL:   simple_res = op1 >> shamt;
            OP_SLL:   simple_res = op1 << shamt;
            OP_SRA:   simple_res = $signed(op1) >>> shamt;
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_DIV, OP_REM: simple_res = '0;
        endcase
    end

    generate
        if (MULDIV_EN) begin : g_md
            alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
                .clk    (clk),
                .rst_n  (rst_n),
                .kill   (kill),
                .start  (start_md),
                .op     (alu_op),
                .a      (op1),
                .b      (op2),
                .done   (md_done),
                .result (md_result)
            );
        end else begin : g_nomd
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

    // Control FSM and output register; kill wins over any same-cycle accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            result <= '0;
            zero   <= 1'b1;
        end else if (kill) begin
            state <= ST_IDLE;
        end else if (accept) begin
            if (start_md) begin
                state <= ST_BUSY;
            end else begin
                state  <= ST_DONE;
                result <= simple_res;
                zero   <= (simple_res == '0);
            end
        end else begin
            case (state)
                ST_BUSY: begin
                    if (md_done) begin
                        state  <= ST_DONE;
                        result <= md_result;
                        zero   <= (md_result == '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (XLEN=32 and XLEN=8 instances).
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, kill, in_valid, out_ready;
    logic [31:0] op1, op2;
    logic [3:0]  alu_op;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;

    logic        kill8, in_valid8, out_ready8;
    logic [7:0]  op1_8, op2_8;
    logic [3:0]  alu_op8;
    logic        in_ready8, out_valid8, zero8, busy8;
    logic [7:0]  result8;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    alu_seq #(.XLEN(8), .MULDIV_EN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .kill(kill8), .in_valid(in_valid8), .in_ready(in_ready8),
        .op1(op1_8), .op2(op2_8), .alu_op(alu_op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .zero(zero8), .busy(busy8)
    );

    // Issue one op from IDLE, scramble inputs after accept, wait for out_valid, then consume it.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int lat, output bit rdy_low);
        in_valid = 1'b1; alu_op = op; op1 = a; op2 = b; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; op1 = 32'hDEADBEEF; op2 = 32'h12345678; alu_op = 4'b0010;
        lat = 1; rdy_low = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = result; z = zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] res, output int lat);
        in_valid8 = 1'b1; alu_op8 = op; op1_8 = a; op2_8 = b; out_ready8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0; op1_8 = 8'h5A; op2_8 = 8'hA5;
        lat = 1;
        while (!out_valid8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result8;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
        n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b expected 1", zero); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL reset8_out_valid: got %b expected 0", out_valid8); end
    endtask

    task automatic test_simple;
        logic [3:0]  ops [10];
        logic [31:0] as  [10];
        logic [31:0] bs  [10];
        logic [31:0] exp [10];
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          rl;
        ops = '{4'b0010, 4'b1010, 4'b0000, 4'b0001, 4'b0110, 4'b0111, 4'b0101, 4'b1000, 4'b1001, 4'b1101};
        as  = '{32'hFFFFFFFF, 32'h80000000, 32'hF0F0F0F0, 32'h0F000000, 32'h00000000,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'hAAAA5555};
        bs  = '{32'h00000001, 32'h00000004, 32'hFF00FF00, 32'h000000F0, 32'h00000001,
                32'h00000001, 32'h00000001, 32'h00000004, 32'h00000021, 32'hFFFF0000};
        exp = '{32'h00000000, 32'hF8000000, 32'hF000F000, 32'h0F0000F0, 32'hFFFFFFFF,
                32'h00000001, 32'h00000000, 32'h08000000, 32'h00000002, 32'h55555555};
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], as[i], bs[i], res, z, lat, rl);
            n_cmp++; if (res !== exp[i]) begin n_err++; $display("FAIL simple_result[%0d] op=%b: got %h expected %h", i, ops[i], res, exp[i]); end
            n_cmp++; if (z !== (exp[i] == 32'h0)) begin n_err++; $display("FAIL simple_zero[%0d]: got %b expected %b", i, z, exp[i] == 32'h0); end
            n_cmp++; if (lat != 1) begin n_err++; $display("FAIL simple_latency[%0d]: got %0d expected 1", i, lat); end
        end
    endtask

    task automatic test_muldiv;
        logic [3:0]  ops [12];
        logic [31:0] as  [12];
        logic [31:0] bs  [12];
        logic [31:0] exp [12];
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          rl;
        ops = '{4'b0011, 4'b0100, 4'b1110, 4'b1111, 4'b1011, 4'b1100,
                4'b1110, 4'b1111, 4'b0011, 4'b0100, 4'b1011, 4'b1100};
        as  = '{32'h00010000, 32'h00010000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5,
                32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100};
        bs  = '{32'h00010000, 32'h00010000, 32'd2, 32'd2, 32'd0, 32'd0,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7};
        exp = '{32'h00000000, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5,
                32'h80000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFE, 32'd14, 32'd2};
        for (int i = 0; i < 12; i++) begin
            run_op(ops[i], as[i], bs[i], res, z, lat, rl);
            n_cmp++; if (res !== exp[i]) begin n_err++; $display("FAIL muldiv_result[%0d] op=%b: got %h expected %h", i, ops[i], res, exp[i]); end
            n_cmp++; if (lat != 33) begin n_err++; $display("FAIL muldiv_latency[%0d]: got %0d expected 33", i, lat); end
            n_cmp++; if (rl !== 1'b1) begin n_err++; $display("FAIL muldiv_in_ready_low[%0d]: got %b expected 1", i, rl); end
        end
    endtask

    task automatic test_back_to_back;
        in_valid = 1'b1; alu_op = 4'b0010; op1 = 32'd1; op2 = 32'd2; out_ready = 1'b0;
        @(posedge clk); #1;
        alu_op = 4'b0110; op1 = 32'd10; op2 = 32'd3;
        repeat (10) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_out_valid: got %b expected 1", out_valid); end
            n_cmp++; if (result !== 32'd3) begin n_err++; $display("FAIL hold_result: got %h expected 00000003", result); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready: got %b expected 0", in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_out_valid: got %b expected 1", out_valid); end
        n_cmp++; if (result !== 32'd7) begin n_err++; $display("FAIL b2b_result: got %h expected 00000007", result); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_kill;
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          rl;
        bit          seen;
        in_valid = 1'b1; alu_op = 4'b1011; op1 = 32'd100; op2 = 32'd7; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL kill_busy: got %b expected 0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL kill_in_ready: got %b expected 1", in_ready); end
        seen = 1'b0;
        repeat (40) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL kill_no_output: got %b expected 0", seen); end
        in_valid = 1'b1; kill = 1'b1; alu_op = 4'b0010; op1 = 32'd1; op2 = 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL kill_drops_accept: got %b expected 0", out_valid); end
        run_op(4'b0010, 32'd2, 32'd3, res, z, lat, rl);
        n_cmp++; if (res !== 32'd5) begin n_err++; $display("FAIL post_kill_add: got %h expected 00000005", res); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL post_kill_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_reset_mid_mul;
        bit seen;
        in_valid = 1'b1; alu_op = 4'b0011; op1 = 32'd3; op2 = 32'd5; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midmul_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL rst_mid_result: got %h expected 00000000", result); end
        n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL rst_mid_zero: got %b expected 1", zero); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_output: got %b expected 0", seen); end
    endtask

    task automatic test_xlen8;
        logic [7:0] res;
        int         lat;
        run_op8(4'b0100, 8'hFF, 8'hFF, res, lat);
        n_cmp++; if (res !== 8'hFE) begin n_err++; $display("FAIL x8_mulhu: got %h expected fe", res); end
        n_cmp++; if (lat != 9) begin n_err++; $display("FAIL x8_latency: got %0d expected 9", lat); end
        run_op8(4'b0011, 8'hFF, 8'hFF, res, lat);
        n_cmp++; if (res !== 8'h01) begin n_err++; $display("FAIL x8_mul: got %h expected 01", res); end
        run_op8(4'b1110, 8'hF9, 8'h02, res, lat);
        n_cmp++; if (res !== 8'hFD) begin n_err++; $display("FAIL x8_div: got %h expected fd", res); end
        run_op8(4'b1010, 8'h80, 8'h0B, res, lat);
        n_cmp++; if (res !== 8'hF0) begin n_err++; $display("FAIL x8_sra: got %h expected f0", res); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL x8_simple_latency: got %0d expected 1", lat); end
    endtask

    initial begin
        rst_n = 1'b0; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; alu_op = '0;
        kill8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0;
        op1_8 = '0; op2_8 = '0; alu_op8 = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_simple;
        test_muldiv;
        test_back_to_back;
        test_kill;
        test_reset_mid_mul;
        test_xlen8;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
